// File: rtl/subword_mem_ctrl_if.sv
// subword_mem_ctrl_if: request/response and word-memory bundle
// for the sub-word load/store sequencer.
interface subword_mem_ctrl_if #(
  parameter int ADDR_W = 30
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport slave (
    input  req_valid, req_we, req_size, req_signed,
    input  req_addr, req_wdata, resp_ready,
    input  mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed,
    output req_addr, req_wdata, resp_ready,
    output mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/subword_mem_ctrl.sv
// subword_mem_ctrl: big-endian load/store sequencer, RMW sub-word stores.
// Define SUBWORD_MEM_CTRL_BYTE_EN to enable byte loads and stores.
module subword_mem_ctrl #(
  parameter int ADDR_W  = 30,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst_n,
  subword_mem_ctrl_if.slave bus
);
  localparam int CW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int TLIM = (TIMEOUT < 1) ? 0 : TIMEOUT - 1;
`ifdef SUBWORD_MEM_CTRL_BYTE_EN
  localparam int OW = 2;
`else
  localparam int OW = 1;
`endif

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [OW-1:0]     off_q, off_d;
  logic [15:0]       wd_q, wd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mreq_q, mreq_d;
  logic              mwe_q, mwe_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       mwd_q, mwd_d;
  logic              rv_q, rv_d;
  logic              rerr_q, rerr_d;
  logic [31:0]       rd_q, rd_d;
  logic              bad;
  logic              tmo;

  function automatic logic [31:0] extract(
    input logic [31:0]   w,
    input logic [1:0]    sz,
    input logic [OW-1:0] off,
    input logic          s
  );
    logic [31:0] r;
    logic [15:0] h;
`ifdef SUBWORD_MEM_CTRL_BYTE_EN
    logic [7:0]  b;
    unique case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
`endif
    r = w;
    h = off[OW-1] ? w[15:0] : w[31:16];
    if (sz == SZ_H)
      r = {{16{s & h[15]}}, h};
`ifdef SUBWORD_MEM_CTRL_BYTE_EN
    else if (sz == SZ_B)
      r = {{24{s & b[7]}}, b};
`endif
    return r;
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0]   w,
    input logic [15:0]   d,
    input logic [1:0]    sz,
    input logic [OW-1:0] off
  );
    logic [31:0] r;
    r = w;
    if (sz == SZ_H) begin
      if (off[OW-1]) r[15:0] = d;
      else           r[31:16] = d;
    end
`ifdef SUBWORD_MEM_CTRL_BYTE_EN
    else if (sz == SZ_B) begin
      unique case (off)
        2'd0:    r[31:24] = d[7:0];
        2'd1:    r[23:16] = d[7:0];
        2'd2:    r[15:8]  = d[7:0];
        default: r[7:0]   = d[7:0];
      endcase
    end
`endif
    return r;
  endfunction

  // flag requests that must be answered with an error, no memory access
  always_comb begin
    bad = 1'b0;
    unique case (bus.req_size)
      SZ_H:    bad = bus.req_addr[0];
      SZ_W:    bad = |bus.req_addr[1:0];
`ifdef SUBWORD_MEM_CTRL_BYTE_EN
      SZ_B:    bad = 1'b0;
`else
      SZ_B:    bad = 1'b1;
`endif
      default: bad = 1'b1;
    endcase
  end

  assign tmo = (TIMEOUT != 0) && (cnt_q == CW'(TLIM));

  // next state and next registered outputs
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    off_d   = off_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    mreq_d  = mreq_q;
    mwe_d   = mwe_q;
    maddr_d = maddr_q;
    mwd_d   = mwd_q;
    rv_d    = rv_q;
    rerr_d  = rerr_q;
    rd_d    = rd_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d   = bus.req_we;
          size_d = bus.req_size;
          sgn_d  = bus.req_signed;
          off_d  = bus.req_addr[1 -: OW];
          wd_d   = bus.req_wdata[15:0];
          if (bad) begin
            state_d = RESP;
            rv_d    = 1'b1;
            rerr_d  = 1'b1;
            rd_d    = '0;
          end else begin
            maddr_d = bus.req_addr[ADDR_W+1:2];
            mreq_d  = 1'b1;
            cnt_d   = '0;
            if (bus.req_we && bus.req_size == SZ_W) begin
              state_d = WR;
              mwe_d   = 1'b1;
              mwd_d   = bus.req_wdata;
            end else begin
              state_d = RD;
              mwe_d   = 1'b0;
            end
          end
        end
      end
      RD: begin
        if (bus.mem_ack) begin
          if (we_q) begin
            // read half of the RMW: keep mem_req up into the write
            state_d = WR;
            mwe_d   = 1'b1;
            mwd_d   = merge(bus.mem_rdata, wd_q, size_q, off_q);
            cnt_d   = '0;
          end else begin
            state_d = RESP;
            mreq_d  = 1'b0;
            rv_d    = 1'b1;
            rd_d    = extract(bus.mem_rdata, size_q, off_q, sgn_q);
          end
        end else if (tmo) begin
          state_d = RESP;
          mreq_d  = 1'b0;
          rv_d    = 1'b1;
          rerr_d  = 1'b1;
          cnt_d   = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WR: begin
        if (bus.mem_ack) begin
          state_d = RESP;
          mreq_d  = 1'b0;
          mwe_d   = 1'b0;
          rv_d    = 1'b1;
        end else if (tmo) begin
          state_d = RESP;
          mreq_d  = 1'b0;
          mwe_d   = 1'b0;
          rv_d    = 1'b1;
          rerr_d  = 1'b1;
          cnt_d   = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
          rv_d    = 1'b0;
          rerr_d  = 1'b0;
          rd_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      off_q   <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      mreq_q  <= 1'b0;
      mwe_q   <= 1'b0;
      maddr_q <= '0;
      mwd_q   <= '0;
      rv_q    <= 1'b0;
      rerr_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      off_q   <= off_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      mreq_q  <= mreq_d;
      mwe_q   <= mwe_d;
      maddr_q <= maddr_d;
      mwd_q   <= mwd_d;
      rv_q    <= rv_d;
      rerr_q  <= rerr_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = rv_q;
  assign bus.resp_err   = rerr_q;
  assign bus.resp_rdata = rd_q;
  assign bus.mem_req    = mreq_q;
  assign bus.mem_we     = mwe_q;
  assign bus.mem_addr   = maddr_q;
  assign bus.mem_wdata  = mwd_q;
endmodule

// File: tb/tb_subword_mem_ctrl.sv
// tb_subword_mem_ctrl: directed vector bench with a word-memory model.
// Byte-lane expectations follow SUBWORD_MEM_CTRL_BYTE_EN.
module tb_subword_mem_ctrl;
  localparam int AW = 30;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  subword_mem_ctrl_if #(.ADDR_W(AW)) bus();

  subword_mem_ctrl #(.ADDR_W(AW), .TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0]   marr [0:255];
  logic          ack_en;
  int            ack_dly;
  int            wcnt;
  int            n_rd = 0;
  int            n_wr = 0;
  int            n_rc = 0;
  logic [AW-1:0] last_a;
  logic          pl_en;
  logic [7:0]    pl_a;
  logic [31:0]   pl_d;

  assign bus.mem_ack   = bus.mem_req && ack_en && (wcnt >= ack_dly);
  assign bus.mem_rdata = marr[bus.mem_addr[7:0]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= 0;
    end else begin
      if (pl_en) marr[pl_a] <= pl_d;
      if (bus.mem_req) begin
        n_rc <= n_rc + 1;
        if (bus.mem_ack) begin
          wcnt   <= 0;
          last_a <= bus.mem_addr;
          if (bus.mem_we) begin
            marr[bus.mem_addr[7:0]] <= bus.mem_wdata;
            n_wr <= n_wr + 1;
          end else begin
            n_rd <= n_rd + 1;
          end
        end else begin
          wcnt <= wcnt + 1;
        end
      end else begin
        wcnt <= 0;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_a  = a;
    pl_d  = d;
    pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, output int lat);
    chk("req_ready idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.resp_valid) begin
      checks++;
      failures++;
      $display("FAIL resp timeout: got no resp_valid within %0d cycles", lat);
    end
  endtask

  task automatic consume();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("resp_valid drop", 32'(bus.resp_valid), 32'd0);
    chk("resp_err drop", 32'(bus.resp_err), 32'd0);
    chk("resp_rdata clr", bus.resp_rdata, 32'd0);
    chk("req_ready back", 32'(bus.req_ready), 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] init;
    logic        err;
    logic [31:0] rd;
    logic [31:0] word;
    int          rds;
    int          wrs;
    int          rc;
    int          lat;
  } vec_t;

  function automatic vec_t mk(
    input logic we, input logic [1:0] sz, input logic sg,
    input logic [31:0] addr, input logic [31:0] wd,
    input logic [31:0] init, input logic err,
    input logic [31:0] rd, input logic [31:0] word,
    input int rds, input int wrs, input int rc, input int lat);
    vec_t v;
    v.we = we; v.sz = sz; v.sg = sg; v.addr = addr; v.wd = wd;
    v.init = init; v.err = err; v.rd = rd; v.word = word;
    v.rds = rds; v.wrs = wrs; v.rc = rc; v.lat = lat;
    return v;
  endfunction

  localparam int NV = 15;
  localparam logic [31:0] W0 = 32'h8899AABB;

  vec_t v [NV];

  initial begin : main
    int lat, r0, w0, c0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    ack_en  = 1'b1;
    ack_dly = 0;
    pl_en   = 1'b0;
    pl_a    = '0;
    pl_d    = '0;

    v[0]  = mk(0, 2'b01, 1, 32'h102, 0, W0, 0, 32'hFFFFAABB, W0, 1, 0, 1, 2);
    v[1]  = mk(0, 2'b01, 1, 32'h100, 0, W0, 0, 32'hFFFF8899, W0, 1, 0, 1, 2);
    v[2]  = mk(0, 2'b01, 0, 32'h100, 0, W0, 0, 32'h00008899, W0, 1, 0, 1, 2);
    v[3]  = mk(0, 2'b01, 0, 32'h102, 0, W0, 0, 32'h0000AABB, W0, 1, 0, 1, 2);
    v[4]  = mk(1, 2'b01, 0, 32'h102, 32'h00001234, W0, 0, 0,
               32'h88991234, 1, 1, 2, 3);
    v[5]  = mk(1, 2'b01, 0, 32'h100, 32'hFFFF5678, W0, 0, 0,
               32'h5678AABB, 1, 1, 2, 3);
    v[6]  = mk(1, 2'b10, 0, 32'h104, 32'hDEADBEEF, 0, 0, 0,
               32'hDEADBEEF, 0, 1, 1, 2);
    v[7]  = mk(0, 2'b10, 1, 32'h104, 0, 32'h01234567, 0, 32'h01234567,
               32'h01234567, 1, 0, 1, 2);
    v[8]  = mk(0, 2'b01, 1, 32'h101, 0, W0, 1, 0, W0, 0, 0, 0, 1);
    v[9]  = mk(0, 2'b11, 0, 32'h100, 0, W0, 1, 0, W0, 0, 0, 0, 1);
    v[10] = mk(0, 2'b10, 0, 32'h102, 0, W0, 1, 0, W0, 0, 0, 0, 1);
`ifdef SUBWORD_MEM_CTRL_BYTE_EN
    v[11] = mk(0, 2'b00, 1, 32'h101, 0, W0, 0, 32'hFFFFFF99, W0, 1, 0, 1, 2);
    v[12] = mk(0, 2'b00, 0, 32'h103, 0, W0, 0, 32'h000000BB, W0, 1, 0, 1, 2);
    v[13] = mk(1, 2'b00, 0, 32'h102, 32'h000000CC, W0, 0, 0,
               32'h8899CCBB, 1, 1, 2, 3);
    v[14] = mk(0, 2'b00, 1, 32'h101, 0, 32'h12345678, 0, 32'h00000034,
               32'h12345678, 1, 0, 1, 2);
`else
    v[11] = mk(0, 2'b00, 1, 32'h101, 0, W0, 1, 0, W0, 0, 0, 0, 1);
    v[12] = mk(0, 2'b00, 0, 32'h103, 0, W0, 1, 0, W0, 0, 0, 0, 1);
    v[13] = mk(1, 2'b00, 0, 32'h102, 32'h000000CC, W0, 1, 0, W0, 0, 0, 0, 1);
    v[14] = mk(0, 2'b00, 1, 32'h101, 0, 32'h12345678, 1, 0,
               32'h12345678, 0, 0, 0, 1);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst mem_wdata", bus.mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      preload(v[i].addr[9:2], v[i].init);
      r0 = n_rd; w0 = n_wr; c0 = n_rc;
      issue(v[i].we, v[i].sz, v[i].sg, v[i].addr, v[i].wd, lat);
      chk($sformatf("v%0d err", i), 32'(bus.resp_err), 32'(v[i].err));
      chk($sformatf("v%0d rdata", i), bus.resp_rdata, v[i].rd);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(v[i].lat));
      consume();
      chk($sformatf("v%0d reads", i), 32'(n_rd - r0), 32'(v[i].rds));
      chk($sformatf("v%0d writes", i), 32'(n_wr - w0), 32'(v[i].wrs));
      chk($sformatf("v%0d req cycles", i), 32'(n_rc - c0), 32'(v[i].rc));
      chk($sformatf("v%0d word", i), marr[v[i].addr[9:2]], v[i].word);
      if (v[i].rc != 0)
        chk($sformatf("v%0d mem_addr", i), 32'(last_a),
            {2'b00, v[i].addr[31:2]});
    end

    // error response held while resp_ready stays low
    c0 = n_rc;
    issue(1'b0, 2'b01, 1'b0, 32'h101, 0, lat);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d resp_valid", k), 32'(bus.resp_valid), 32'd1);
      chk($sformatf("hold%0d req_ready", k), 32'(bus.req_ready), 32'd0);
      chk($sformatf("hold%0d resp_err", k), 32'(bus.resp_err), 32'd1);
    end
    consume();
    chk("hold req cycles", 32'(n_rc - c0), 32'd0);

    // timeout on a half store: four request cycles, no write
    preload(8'h40, W0);
    ack_en = 1'b0;
    r0 = n_rd; w0 = n_wr; c0 = n_rc;
    issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h00001234, lat);
    chk("tmo err", 32'(bus.resp_err), 32'd1);
    chk("tmo rdata", bus.resp_rdata, 32'd0);
    chk("tmo latency", 32'(lat), 32'd5);
    consume();
    chk("tmo req cycles", 32'(n_rc - c0), 32'd4);
    chk("tmo writes", 32'(n_wr - w0), 32'd0);
    chk("tmo word", marr[8'h40], W0);
    ack_en = 1'b1;

    // ack on the last cycle before timeout still succeeds
    ack_dly = 3;
    c0 = n_rc;
    issue(1'b0, 2'b01, 1'b1, 32'h100, 0, lat);
    chk("edge err", 32'(bus.resp_err), 32'd0);
    chk("edge rdata", bus.resp_rdata, 32'hFFFF8899);
    chk("edge latency", 32'(lat), 32'd5);
    consume();
    chk("edge req cycles", 32'(n_rc - c0), 32'd4);

    // wait-stated read-modify-write
    ack_dly = 2;
    c0 = n_rc;
    issue(1'b1, 2'b01, 1'b0, 32'h100, 32'h0000ABCD, lat);
    chk("ws err", 32'(bus.resp_err), 32'd0);
    chk("ws latency", 32'(lat), 32'd7);
    consume();
    chk("ws req cycles", 32'(n_rc - c0), 32'd6);
    chk("ws word", marr[8'h40], 32'hABCDAABB);
    ack_dly = 0;

    // reset in the middle of a stalled access
    preload(8'h40, W0);
    ack_en = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b01;
    bus.req_signed = 1'b1;
    bus.req_addr   = 32'h100;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid mem_req", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid rst mem_req", 32'(bus.mem_req), 32'd0);
    chk("mid rst mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("mid rst mem_we", 32'(bus.mem_we), 32'd0);
    chk("mid rst mem_wdata", bus.mem_wdata, 32'd0);
    chk("mid rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("mid rst resp_err", 32'(bus.resp_err), 32'd0);
    chk("mid rst resp_rdata", bus.resp_rdata, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    ack_en = 1'b1;
    @(posedge clk); #1;
    chk("post rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("post rst mem_req", 32'(bus.mem_req), 32'd0);

    issue(1'b0, 2'b01, 1'b1, 32'h102, 0, lat);
    chk("recover rdata", bus.resp_rdata, 32'hFFFFAABB);
    chk("recover latency", 32'(lat), 32'd2);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/subword_mem_ctrl.md
Name: subword_mem_ctrl

Overview:
- Load/store sequencer between the MEM stage and a 32-bit word-wide data memory.
- Big-endian: byte offset 0 = bits 31:24; halfword offset 0 = bits 31:16.
- Sub-word stores run as read-modify-write. Sub-word loads are extracted and sign- or zero-extended.
- Misaligned accesses are rejected. Stalled memory accesses are aborted on timeout.

Parameters:
ADDR_W, 30, word-address width on the memory side (mem_addr = req_addr[ADDR_W+1:2])
TIMEOUT, 255, max cycles to wait for mem_ack per memory access; 0 = wait forever

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request (state IDLE)
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  input  1  sign-extend load result
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  response available
resp_ready  input  1  response consumed
resp_rdata  output  32  load result (0 for stores and errors)
resp_err  output  1  misaligned, illegal size, or timeout
mem_req  output  1  memory access active
mem_we  output  1  memory write
mem_addr  output  ADDR_W  word address
mem_wdata  output  32  full word to write
mem_rdata  input  32  read word, valid when mem_ack is high on a read
mem_ack  input  1  access complete; sampled only while mem_req=1

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - resp_valid, resp_err, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata and the timeout counter all go to 0.
  - Any in-flight memory access is abandoned; the memory is reset alongside.
- req_ready = (state==IDLE) and is combinational. A request is accepted on req_valid & req_ready, and all req_* fields are captured.
- States:
  - IDLE:
    - Error request (half with addr[0]=1; word with addr[1:0]!=0; size 11) goes to RESP with resp_err=1. No memory access.
    - Word store goes to WR.
    - Any load or sub-word store goes to RD.
  - RD:
    - Holds mem_req=1, mem_we=0.
    - On mem_ack:
      - Load: extract lane into resp_rdata, then go to RESP.
      - Sub-word store: merge data into the read word, register it into mem_wdata, then go to WR.
  - WR:
    - Holds mem_req=1, mem_we=1.
    - Merge: half replaces the lane selected by addr[1]; byte replaces the lane selected by addr[1:0]; other bytes are preserved.
    - On mem_ack, go to RESP.
  - RESP:
    - resp_valid=1 with stable outputs until resp_ready.
    - On resp_valid & resp_ready, go to IDLE. resp_valid, resp_err and resp_rdata return to 0.
- Memory handshake:
  - mem_req is registered; it asserts the cycle after the state is entered and drops the cycle after mem_ack.
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1.
  - mem_ack while mem_req=0 is ignored.
- Latency (zero-wait memory, ack in the first mem_req cycle):
  - Load or word store: request accepted at T, resp_valid at T+2.
  - Sub-word store: resp_valid at T+3.
- Timeout:
  - Counter clears on entering RD or WR and increments every cycle mem_req=1 without mem_ack.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT, mem_req drops and the state goes to RESP with resp_err=1. A sub-word store never reaches WR in this case.
- mem_ack arriving in the same cycle the counter reaches TIMEOUT counts as a success.
- Load extraction:
  - Half offset 0 = [31:16]; half offset 2 = [15:0].
  - Byte offset k = bits [31-8k -: 8].
  - Extension follows req_signed. Word loads return the word unchanged.
- A new request is not accepted in the same cycle a response completes; back-to-back requests have one IDLE cycle between them.

Optional Feature:
- Macro: SUBWORD_MEM_CTRL_BYTE_EN.
- Defined: byte loads and stores are supported as above.
- Undefined: req_size=00 is treated as illegal (RESP with resp_err=1, no memory access), and the byte lane mux/merge logic is not synthesized. Halfword and word behaviour is identical in both builds.

Test Plan:
- Memory word at 0x100 = 0x8899AABB. Half loads:
  - addr 0x102, signed -> resp_rdata=0xFFFFAABB.
  - addr 0x100, signed -> 0xFFFF8899.
  - addr 0x100, unsigned -> 0x00008899.
  - Each causes exactly one read with mem_addr=0x40.
- Half store, wdata 0x00001234, addr 0x102 -> one read, then one write of 0x88991234 to word 0x40; resp_err=0; resp_valid at T+3 with zero-wait memory.
- Word store 0xDEADBEEF, addr 0x104 -> no read; single write with mem_addr=0x41, mem_wdata=0xDEADBEEF.
- Misaligned half addr 0x101, or size 11 -> resp_err=1, resp_rdata=0, mem_req never asserted. Hold resp_ready=0 for 3 cycles -> resp_valid stays high and req_ready stays 0.
- TIMEOUT=4, mem_ack never asserted on a half store:
  - mem_req high for exactly 4 cycles, then resp_err=1 and no write issued.
  - Assert rst_n=0 mid-access in a separate run -> all outputs 0 immediately, req_ready=1 after release.
- Byte load, signed, addr 0x101, word 0x8899AABB:
  - With macro defined -> 0xFFFFFF99.
  - With macro undefined -> resp_err=1 and no memory access.
